// File: rtl/ad9945_cfg_rx.sv
// AD9945 3-wire configuration port receiver: oversampled SL/SCK/SDATA decode into shadow registers.
// Optional build macro AD9945_CFG_RX_STRICT_EN rejects frames with reserved/out-of-range content.
module ad9945_cfg_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 16
) (
   input  logic        sys_clk,
   input  logic        resetn,
   input  logic        SL,
   input  logic        SCK,
   input  logic        SDATA,
   output logic [6:0]  oper,
   output logic [6:0]  ctrl,
   output logic [7:0]  clamp,
   output logic [9:0]  vga_gain,
   output logic        wr_valid,
   output logic [2:0]  wr_addr,
   output logic [11:0] wr_data,
   output logic        frame_err
);

   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      CHECK  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t                  state_r;
   logic [SYNC_STAGES-1:0]  sl_sync_r;
   logic [SYNC_STAGES-1:0]  sck_sync_r;
   logic [SYNC_STAGES-1:0]  sda_sync_r;
   logic                    sl_prev_r;
   logic                    sck_prev_r;
   logic [CW-1:0]           cnt_r;
   logic [FRAME_BITS-1:0]   shreg_r;

   logic        sl_s;
   logic        sl_rise_s;
   logic        sl_fall_s;
   logic        sck_rise_s;
   logic        sda_s;
   logic [2:0]  addr_s;
   logic        rsvd_s;
   logic [11:0] data_s;
   logic        accept_s;
`ifdef AD9945_CFG_RX_STRICT_EN
   logic        fit_s;
`endif

   // Edge detection on the last synchronizer stage against one extra delayed copy.
   always_comb begin
      sl_s       = sl_sync_r[SYNC_STAGES-1];
      sda_s      = sda_sync_r[SYNC_STAGES-1];
      sl_rise_s  = sl_s & ~sl_prev_r;
      sl_fall_s  = ~sl_s & sl_prev_r;
      sck_rise_s = sck_sync_r[SYNC_STAGES-1] & ~sck_prev_r;
      addr_s     = shreg_r[2:0];
      rsvd_s     = shreg_r[3];
      data_s     = shreg_r[15:4];
   end

   // Frame acceptance decision evaluated in CHECK.
   always_comb begin
      accept_s = (cnt_r == CNT_FULL);
`ifdef AD9945_CFG_RX_STRICT_EN
      case (addr_s)
         3'd0, 3'd1: fit_s = (data_s[11:7] == 5'd0);
         3'd2:       fit_s = (data_s[11:8] == 4'd0);
         3'd3:       fit_s = (data_s[11:10] == 2'd0);
         default:    fit_s = 1'b0;
      endcase
      accept_s = accept_s & fit_s & ~rsvd_s;
`endif
   end

   // Synchronizers, frame FSM and registered outputs.
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         // Synchronizers clear to 0 so a writer holding SL low across reset never fakes a falling edge.
         sl_sync_r  <= '0;
         sck_sync_r <= '0;
         sda_sync_r <= '0;
         sl_prev_r  <= 1'b0;
         sck_prev_r <= 1'b0;
         state_r    <= IDLE;
         cnt_r      <= '0;
         shreg_r    <= '0;
         oper       <= 7'd0;
         ctrl       <= 7'd0;
         clamp      <= 8'd0;
         vga_gain   <= 10'd0;
         wr_valid   <= 1'b0;
         wr_addr    <= 3'd0;
         wr_data    <= 12'd0;
         frame_err  <= 1'b0;
      end else begin
         sl_sync_r  <= {sl_sync_r[SYNC_STAGES-2:0], SL};
         sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], SDATA};
         sl_prev_r  <= sl_s;
         sck_prev_r <= sck_sync_r[SYNC_STAGES-1];
         wr_valid   <= 1'b0;
         frame_err  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (sl_fall_s) begin
                  cnt_r   <= '0;
                  state_r <= SHIFT;
               end else begin
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               // SL rising wins over a coincident SCK edge.
               if (sl_rise_s) begin
                  state_r <= CHECK;
               end else if (sck_rise_s) begin
                  shreg_r <= {sda_s, shreg_r[FRAME_BITS-1:1]};
                  if (cnt_r != CNT_MAX) begin
                     cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  end
               end
            end
            CHECK: begin
               // Commit results are registered here so they are visible during the COMMIT cycle.
               if (accept_s) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= addr_s;
                  wr_data  <= data_s;
                  case (addr_s)
                     3'd0:    oper     <= data_s[6:0];
                     3'd1:    ctrl     <= data_s[6:0];
                     3'd2:    clamp    <= data_s[7:0];
                     3'd3:    vga_gain <= data_s[9:0];
                     default: oper     <= oper;
                  endcase
                  state_r <= COMMIT;
               end else begin
                  frame_err <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            COMMIT:  state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad9945_cfg_rx.sv
// Scoreboard bench for ad9945_cfg_rx: a frame-level model queues expected events, a monitor checks them.
module tb_ad9945_cfg_rx;

   logic        clk = 1'b0;
   logic        resetn;
   logic        SL;
   logic        SCK;
   logic        SDATA;
   logic [6:0]  oper;
   logic [6:0]  ctrl;
   logic [7:0]  clamp;
   logic [9:0]  vga_gain;
   logic        wr_valid;
   logic [2:0]  wr_addr;
   logic [11:0] wr_data;
   logic        frame_err;

   ad9945_cfg_rx dut (
      .sys_clk(clk), .resetn(resetn), .SL(SL), .SCK(SCK), .SDATA(SDATA),
      .oper(oper), .ctrl(ctrl), .clamp(clamp), .vga_gain(vga_gain),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      int          regs[4];
      int          wa;
      int          wd;
   } ev_t;

   ev_t exp_q[$];
   int  m_reg[4];
   int  m_wa;
   int  m_wd;
   int  n_vec = 0;
   int  n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int reg_w(input int a);
      case (a)
         0, 1:    return 7;
         2:       return 8;
         default: return 10;
      endcase
   endfunction

   // Reference model: decides the fate of a whole frame from its bit count and content.
   function automatic void model_frame(input int nbits, input logic [31:0] bits);
      ev_t e;
      int  a, d;
      bit  ok;
      ok = (nbits == 16);
      a  = int'(bits[2:0]);
      d  = int'(bits[15:4]);
`ifdef AD9945_CFG_RX_STRICT_EN
      if (bits[3] || a > 3 || d >= (1 << reg_w(a))) ok = 1'b0;
`endif
      if (ok) begin
         m_wa = a;
         m_wd = d;
         if (a < 4) m_reg[a] = d % (1 << reg_w(a));
      end
      e.is_err = !ok;
      e.regs   = m_reg;
      e.wa     = m_wa;
      e.wd     = m_wd;
      exp_q.push_back(e);
   endfunction

   function automatic logic [31:0] frm(input int a, input int d);
      logic [31:0] v;
      v = 32'd0;
      v[2:0]  = 3'(a);
      v[15:4] = 12'(d);
      return v;
   endfunction

   // Monitor: every output pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      ev_t e;
      if (resetn && (wr_valid || frame_err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, wr_valid, frame_err}, 0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {30'd0, wr_valid, frame_err}, e.is_err ? 1 : 2);
            chk("wr_addr", int'(wr_addr), e.wa);
            chk("wr_data", int'(wr_data), e.wd);
            chk("oper", int'(oper), e.regs[0]);
            chk("ctrl", int'(ctrl), e.regs[1]);
            chk("clamp", int'(clamp), e.regs[2]);
            chk("vga_gain", int'(vga_gain), e.regs[3]);
         end
      end
   end

   task automatic send_bits(input int n, input logic [31:0] bits, input int first);
      for (int i = 0; i < n; i++) begin
         SCK   = 1'b0;
         SDATA = bits[first + i];
         repeat (4) @(posedge clk);
         SCK = 1'b1;
         repeat (4) @(posedge clk);
      end
      SCK = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_frame(input int nbits, input logic [31:0] bits);
      model_frame(nbits, bits);
      SL = 1'b0;
      repeat (4) @(posedge clk);
      send_bits(nbits, bits, 0);
      SL = 1'b1;
      repeat (10) @(posedge clk);
      chk("frame_drained", exp_q.size(), 0);
   endtask

   task automatic check_idle_outputs();
      chk("rst_oper", int'(oper), 0);
      chk("rst_ctrl", int'(ctrl), 0);
      chk("rst_clamp", int'(clamp), 0);
      chk("rst_vga_gain", int'(vga_gain), 0);
      chk("rst_wr", {19'd0, wr_valid, wr_addr, wr_data}, 0);
      chk("rst_frame_err", int'(frame_err), 0);
   endtask

   initial begin
      logic [31:0] r;
      int          nb;
      resetn = 1'b0;
      SL = 1'b1; SCK = 1'b0; SDATA = 1'b0;
      m_reg = '{0, 0, 0, 0}; m_wa = 0; m_wd = 0;
      repeat (5) @(posedge clk);
      #1 check_idle_outputs();
      resetn = 1'b1;
      repeat (5) @(posedge clk);

      send_frame(16, frm(0, 12'h055));
      chk("t1_oper", int'(oper), 7'h55);

      send_frame(16, frm(0, 12'h055));
      send_frame(16, frm(1, 12'h055));
      send_frame(16, frm(2, 12'h055));
      send_frame(16, frm(3, 12'h155));
      chk("t2_vga_gain", int'(vga_gain), 10'h155);

      send_frame(10, frm(1, 12'h3FF));
      send_frame(16, frm(2, 12'h0AA));
      chk("t3_clamp", int'(clamp), 8'hAA);

      send_frame(17, $urandom);
      send_frame(16, frm(5, 12'hFFF));

      // Reset in the middle of an addr 3 frame, then finish its bits with no write expected.
      r = frm(3, 12'h2AB);
      SL = 1'b0;
      repeat (4) @(posedge clk);
      send_bits(8, r, 0);
      resetn = 1'b0;
      m_reg = '{0, 0, 0, 0}; m_wa = 0; m_wd = 0;
      repeat (2) @(posedge clk);
      #1 check_idle_outputs();
      resetn = 1'b1;
      send_bits(8, r, 8);
      SL = 1'b1;
      repeat (10) @(posedge clk);
      chk("t5_no_event", exp_q.size(), 0);
      send_frame(16, frm(3, 12'h123));

      // SCK activity while SL is high must be ignored.
      for (int i = 0; i < 20; i++) begin
         SDATA = 1'($urandom);
         SCK   = ~SCK;
         repeat (3) @(posedge clk);
      end
      SCK = 1'b0;
      repeat (10) @(posedge clk);
      chk("t6_oper_hold", int'(oper), m_reg[0]);

      for (int k = 0; k < 50; k++) begin
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
         r  = $urandom;
         if ($urandom_range(0, 1) == 1) r[3] = 1'b0;
         if ($urandom_range(0, 1) == 1) r[2] = 1'b0;
         send_frame(nb, r);
      end

      chk("end_oper", int'(oper), m_reg[0]);
      chk("end_ctrl", int'(ctrl), m_reg[1]);
      chk("end_clamp", int'(clamp), m_reg[2]);
      chk("end_vga_gain", int'(vga_gain), m_reg[3]);
      chk("end_queue", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ad9945_cfg_rx.md
Name: ad9945_cfg_rx

Overview:
- Receiving end of the AD9945 3-wire serial configuration port (SL, SCK, SDATA).
- Oversamples the port on the system clock and decodes each write frame.
- Holds a shadow copy of the Oper/Ctrl/Clamp/VGA_Gain registers and pulses a write strobe per accepted frame.
- Used in the CCD/AFE simulation bench as the AFE-side model. Also synthesizable for loopback checks of the config writer on hardware.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SL/SCK/SDATA; legal values are 2 or 3.
- FRAME_BITS, 16, bits per write frame: 3 address bits, 1 reserved bit, 12 data bits.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge
- resetn  input  1  asynchronous, active-low reset
- SL  input  1  serial load/select from the config writer; active-low frame enable
- SCK  input  1  serial clock from the writer; data sampled on its rising edge
- SDATA  input  1  serial data, LSB first
- oper  output  7  shadow register, address 0, D[6:0]
- ctrl  output  7  shadow register, address 1, D[6:0]
- clamp  output  8  shadow register, address 2, D[7:0]
- vga_gain  output  10  shadow register, address 3, D[9:0]
- wr_valid  output  1  one-cycle pulse per accepted frame
- wr_addr  output  3  address of the last accepted frame
- wr_data  output  12  full 12-bit data of the last accepted frame
- frame_err  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; bit counter 0; shift register 0.
- Input conditioning:
  - SL, SCK and SDATA each pass through SYNC_STAGES flops.
  - Edges are detected on the last stage versus one extra delayed copy.
  - SCK high and low phases must each be at least 2 sys_clk periods; faster SCK is out of spec.
- Bit order within a frame: bit0..2 = A0..A2, bit3 = reserved, bit4..15 = D0..D11. Each field is LSB first.
- FSM states:
  - IDLE: wait for a synchronized SL falling edge, then clear the bit counter and go to SHIFT. An SL rising edge, or SCK activity while SL is high, is ignored.
  - SHIFT:
    - On each synchronized SCK rising edge, shift the synchronized SDATA into the shift register (LSB first).
    - The bit counter increments and saturates at FRAME_BITS+1.
    - On an SL rising edge, go to CHECK.
  - CHECK (1 cycle):
    - count == FRAME_BITS goes to COMMIT.
    - Any other count pulses frame_err and returns to IDLE; registers are unchanged.
  - COMMIT (1 cycle):
    - Latch wr_addr and wr_data, and update the addressed shadow register from the low data bits.
    - Pulse wr_valid, then return to IDLE.
    - Addresses 4..7 still pulse wr_valid and update wr_addr/wr_data, but change no shadow register.
- Latency: wr_valid is high exactly 2 sys_clk cycles after the cycle in which the synchronized SL rising edge is detected.
- Shadow registers and wr_addr/wr_data hold their value until the next accepted frame.
- Simultaneous events: if a synchronized SCK rising edge and SL rising edge are detected in the same cycle, SL wins and that SCK edge is not sampled.
- SL falling while in CHECK/COMMIT cannot occur (it requires at least 2 cycles of SL high). If it does, it is ignored and the frame is lost.
- Asserting resetn low mid-frame aborts immediately. The next frame is decoded only after a fresh SL falling edge following reset release.
- Consecutive frames: back-to-back frames with at least 2 sys_clk cycles of SL high are each decoded independently.

Optional Feature:
- Macro: AD9945_CFG_RX_STRICT_EN.
- Defined:
  - CHECK also rejects a frame whose reserved bit3 is 1, or whose address is 4..7.
  - CHECK also rejects a frame whose data bits above the target register width are nonzero.
  - Each rejection pulses frame_err with no wr_valid, and registers are unchanged.
- Not defined: those frames are accepted as described in Behaviour (unused upper bits are dropped silently).

Test Plan:
- Reset, then write addr 0 data 0x055 (16 bits, SCK = sys_clk/8) -> oper = 7'b1010101; wr_valid pulses once; wr_addr = 0; wr_data = 0x055; frame_err stays 0.
- Four frames: addr 0 = 0x055, 1 = 0x055, 2 = 0x055, 3 = 0x155 -> oper = 0x55, ctrl = 0x55, clamp = 0x55, vga_gain = 0x155; exactly 4 wr_valid pulses.
- Frame cut after 10 bits (SL rises early) -> frame_err pulses once, no wr_valid, registers unchanged. A following valid frame (addr 2 data 0x0AA) gives clamp = 0xAA.
- 17-bit frame, then a frame to addr 5 data 0xFFF:
  - 17-bit frame: frame_err pulses.
  - Addr 5 frame without STRICT: wr_valid pulses, wr_addr = 5, shadow registers unchanged.
  - Addr 5 frame with STRICT: frame_err pulses instead.
- resetn pulsed low after 8 bits of an addr 3 frame -> all outputs 0. SCK edges before the next SL falling edge cause no write; the next full frame decodes correctly.
- SCK toggled 20 times while SL is high, followed by an SL rising edge in IDLE -> no wr_valid, no frame_err.
